// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding, idle grant pattern and rotate-priority pick
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] Y_IDLE = 4'b1111;

  // First active-low request in order last+1 .. last+4; scanning downward lets the nearest win.
  function automatic logic [1:0] next_id(input logic [3:0] req_l, input logic [1:0] last);
    logic [1:0] id;
    next_id = last;
    for (int k = 4; k >= 1; k--) begin
      id = last + 2'(k);
      if (!req_l[id]) next_id = id;
    end
  endfunction

endpackage

// File: rtl/dec2to4_l.sv
// rtl/dec2to4_l.sv - active-low-enable 2-to-4 decoder with active-low outputs
module dec2to4_l
  import arb_pkg::*;
(
  input  logic       G_L,
  input  logic       A,
  input  logic       B,
  output logic [3:0] Y_L
);

  always_comb begin
    Y_L = Y_IDLE;
    if (!G_L) Y_L[{B, A}] = 1'b0;
  end

endmodule

// File: rtl/rr_arb4_dec_ctrl.sv
// rtl/rr_arb4_dec_ctrl.sv - round-robin sequencer sharing one 2-to-4 decoder among four requesters
module rr_arb4_dec_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int GAP      = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] REQ_L,
  output logic       G_L,
  output logic       A,
  output logic       B,
  output logic [3:0] Y_L,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       TIMEOUT
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t          state, state_nx;
  logic [1:0]      last, last_nx;
  logic [HW-1:0]   hold_cnt, hold_nx;
  logic [3:0]      gap_cnt, gap_nx;
  logic            g_l_nx, a_nx, b_nx, timeout_nx;
  logic [1:0]      id_sel;

  assign id_sel = next_id(REQ_L, last);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      last     <= 2'd3;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      G_L      <= 1'b1;
      A        <= 1'b0;
      B        <= 1'b0;
      TIMEOUT  <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      hold_cnt <= hold_nx;
      gap_cnt  <= gap_nx;
      G_L      <= g_l_nx;
      A        <= a_nx;
      B        <= b_nx;
      TIMEOUT  <= timeout_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last;
    hold_nx    = hold_cnt;
    gap_nx     = gap_cnt;
    g_l_nx     = G_L;
    a_nx       = A;
    b_nx       = B;
    timeout_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (REQ_L != Y_IDLE) begin
          {b_nx, a_nx} = id_sel;
          g_l_nx       = 1'b0;
          last_nx      = id_sel;
          hold_nx      = HW'(1);
          state_nx     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Voluntary release wins over timeout when both happen on the same edge.
        if (REQ_L[{B, A}] || hold_cnt == HW'(MAX_HOLD)) begin
          g_l_nx     = 1'b1;
          gap_nx     = 4'd1;
          state_nx   = ST_GAP;
          timeout_nx = !REQ_L[{B, A}];
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'(GAP)) state_nx = ST_IDLE;
        else gap_nx = gap_cnt + 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign GNT_ID = {B, A};
  assign BUSY   = (state != ST_IDLE);

  dec2to4_l u_dec (
    .G_L (G_L),
    .A   (A),
    .B   (B),
    .Y_L (Y_L)
  );

endmodule

// File: tb/tb_rr_arb4_dec_ctrl.sv
// tb/tb_rr_arb4_dec_ctrl.sv - scoreboard bench for rr_arb4_dec_ctrl against an ownership model
module tb_rr_arb4_dec_ctrl;

  localparam int MH = 3;
  localparam int GP = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] REQ_L;
  logic       G_L, A, B, BUSY, TIMEOUT;
  logic [3:0] Y_L;
  logic [1:0] GNT_ID;

  always #5 CLK = ~CLK;

  rr_arb4_dec_ctrl #(.MAX_HOLD(MH), .GAP(GP)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ_L   (REQ_L),
    .G_L     (G_L),
    .A       (A),
    .B       (B),
    .Y_L     (Y_L),
    .GNT_ID  (GNT_ID),
    .BUSY    (BUSY),
    .TIMEOUT (TIMEOUT)
  );

  typedef struct {
    logic [3:0] y_l;
    logic       g_l;
    logic [1:0] ab;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: who owns the decoder, for how long, and how many quiet cycles remain.
  int         owner, held, quiet, last_m;
  logic [1:0] ab_m;
  logic       to_m;

  function automatic void model_reset();
    owner  = -1;
    held   = 0;
    quiet  = 0;
    last_m = 3;
    ab_m   = 2'd0;
    to_m   = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] req);
    to_m = 1'b0;
    if (owner >= 0) begin
      if (req[owner] || held == MH) begin
        to_m  = !req[owner];
        owner = -1;
        quiet = GP;
      end else begin
        held++;
      end
    end else if (quiet > 0) begin
      quiet--;
    end else if (req != 4'hF) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last_m + k) % 4;
        if (!req[c]) begin
          owner = c;
          break;
        end
      end
      last_m = owner;
      ab_m   = 2'(owner);
      held   = 1;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.y_l = 4'hF;
    if (owner >= 0) e.y_l[owner] = 1'b0;
    e.g_l     = (owner < 0);
    e.ab      = ab_m;
    e.busy    = (owner >= 0) || (quiet > 0);
    e.timeout = to_m;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("y_l", Y_L, e.y_l);
        check("g_l", G_L, e.g_l);
        check("ab", {B, A}, e.ab);
        check("busy", BUSY, e.busy);
        check("timeout", TIMEOUT, e.timeout);
        check("one_low", ($countones(~Y_L) <= 1), 1);
        if (!e.g_l) check("gnt_id", GNT_ID, e.ab);
      end
    end
  end

  // Called at a negedge; drives REQ_L, lets one edge pass, queues what that edge must produce.
  task automatic tick(input logic [3:0] r);
    REQ_L = r;
    @(posedge CLK);
    if (RESET) model_reset();
    else model_step(r);
    sbq.push_back(model_out());
    @(negedge CLK);
  endtask

  initial begin : stimulus
    logic [3:0] r;
    int         guard;
    RESET = 1'b1;
    REQ_L = 4'hF;
    model_reset();
    #1;
    check("rst_y_l", Y_L, 4'hF);
    check("rst_g_l", G_L, 1'b1);
    check("rst_ab", {B, A}, 2'd0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_timeout", TIMEOUT, 1'b0);
    @(negedge CLK);
    tick(4'hF);
    tick(4'hF);
    RESET = 1'b0;

    repeat (30) tick(4'b0000);
    repeat (4) tick(4'hF);
    repeat (30) tick(4'b1100);
    repeat (4) tick(4'hF);
    tick(4'b0111);
    repeat (6) tick(4'hF);
    tick(4'b1011);
    tick(4'b1011);
    repeat (6) tick(4'hF);
    tick(4'b1011);
    tick(4'b1111);
    tick(4'b1101);
    tick(4'b1101);
    repeat (8) tick(4'b1101);

    guard = 0;
    while (owner < 0 && guard < 20) begin
      tick(4'b1110);
      guard++;
    end
    check("grant_before_reset", (owner >= 0), 1);
    tick(4'b1110);
    RESET = 1'b1;
    #1;
    check("async_y_l", Y_L, 4'hF);
    check("async_g_l", G_L, 1'b1);
    check("async_busy", BUSY, 1'b0);
    model_reset();
    tick(4'b1110);
    RESET = 1'b0;
    tick(4'b1110);
    #2;
    check("post_reset_grant", Y_L, 4'b1110);
    tick(4'hF);

    r = 4'hF;
    repeat (800) begin
      r = r ^ 4'($urandom & $urandom);
      tick(r);
    end

    repeat (8) tick(4'hF);
    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    check("queue_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
